// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - IF/ID instruction queue port bundle
// master = fetch/branch/ID drivers, slave = the queue itself.
interface if_id_queue_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        branch_interception;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        fetch_hold;
  logic        q_full;
  logic        drop_err;

  modport master (
    output if_valid, if_pc, if_inst, branch_interception, id_stall,
    input  id_valid, id_pc, id_inst, fetch_hold, q_full, drop_err
  );

  modport slave (
    input  if_valid, if_pc, if_inst, branch_interception, id_stall,
    output id_valid, id_pc, id_inst, fetch_hold, q_full, drop_err
  );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - circular instruction queue between IF and ID
// Captures every IF word so an ID stall never loses an in-flight fetch; branch flushes all.
module if_id_queue #(
  parameter int DEPTH      = 4,
  parameter int HOLD_LEVEL = 3
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_err_q, drop_err_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic full;
  logic not_empty;
  logic push;
  logic pop;

  // Full is decoded from registered count only, so a same-cycle pop never frees a slot for a push.
  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = bus.if_valid && !full && !bus.branch_interception;
  assign pop       = not_empty && !bus.id_stall && !bus.branch_interception;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q;
    if (bus.branch_interception) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (bus.if_valid && full) drop_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Entry contents need no reset: count_q alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= bus.if_pc;
      inst_mem_q[wr_ptr_q] <= bus.if_inst;
    end
  end

  assign bus.id_valid   = not_empty;
  assign bus.id_pc      = not_empty ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign bus.id_inst    = not_empty ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign bus.fetch_hold = (count_q >= CW'(HOLD_LEVEL));
  assign bus.q_full     = full;
  assign bus.drop_err   = drop_err_q;
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  if_id_queue_if bus ();

  if_id_queue #(.DEPTH(4), .HOLD_LEVEL(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_1357;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic stall, input logic br);
    bus.if_valid            = v;
    bus.if_pc               = pc;
    bus.if_inst             = inst_of(pc);
    bus.id_stall            = stall;
    bus.branch_interception = br;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 ||
        bus.fetch_hold !== 1'b0 || bus.q_full !== 1'b0 || bus.drop_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b pc=%h inst=%h hold=%b full=%b err=%b exp all 0",
               bus.id_valid, bus.id_pc, bus.id_inst, bus.fetch_hold, bus.q_full, bus.drop_err);
    end
  endtask

  task automatic test_in_order();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== pcs[i] || bus.id_inst !== inst_of(pcs[i])) begin
        failures++;
        $display("FAIL in_order[%0d] got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                 i, bus.id_valid, bus.id_pc, bus.id_inst, pcs[i], inst_of(pcs[i]));
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 || bus.id_pc !== 32'h0) begin
      failures++;
      $display("FAIL in_order_empty got v=%b pc=%h inst=%h exp 0 0 0",
               bus.id_valid, bus.id_pc, bus.id_inst);
    end
  endtask

  task automatic test_fill_overflow();
    logic exp_hold [4];
    logic exp_full [4];
    exp_hold = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_full = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
      tick();
      checks++;
      if (bus.fetch_hold !== exp_hold[i] || bus.q_full !== exp_full[i] ||
          bus.id_pc !== 32'h0 || bus.drop_err !== 1'b0) begin
        failures++;
        $display("FAIL fill[%0d] got hold=%b full=%b pc=%h err=%b exp hold=%b full=%b pc=0 err=0",
                 i, bus.fetch_hold, bus.q_full, bus.id_pc, bus.drop_err, exp_hold[i], exp_full[i]);
      end
    end
    drive(1'b1, 32'h10, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.drop_err !== 1'b1 || bus.q_full !== 1'b1 || dut.count_q !== 3'd4 || bus.id_pc !== 32'h0) begin
      failures++;
      $display("FAIL overflow got err=%b full=%b count=%0d pc=%h exp err=1 full=1 count=4 pc=0",
               bus.drop_err, bus.q_full, dut.count_q, bus.id_pc);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * i) || bus.drop_err !== 1'b1) begin
        failures++;
        $display("FAIL drain[%0d] got v=%b pc=%h err=%b exp v=1 pc=%h err=1",
                 i, bus.id_valid, bus.id_pc, bus.drop_err, 32'(4 * i));
      end
    end
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || bus.drop_err !== 1'b1) begin
      failures++;
      $display("FAIL drain_end got v=%b err=%b exp v=0 err=1", bus.id_valid, bus.drop_err);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h20, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h24, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h28, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus.id_valid !== 1'b0 || dut.count_q !== 3'd0 || bus.fetch_hold !== 1'b0 || bus.id_pc !== 32'h0) begin
      failures++;
      $display("FAIL flush got v=%b count=%0d hold=%b pc=%h exp v=0 count=0 hold=0 pc=0",
               bus.id_valid, dut.count_q, bus.fetch_hold, bus.id_pc);
    end
    drive(1'b1, 32'h30, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h30 || dut.count_q !== 3'd1) begin
      failures++;
      $display("FAIL post_flush got v=%b pc=%h count=%0d exp v=1 pc=00000030 count=1",
               bus.id_valid, bus.id_pc, dut.count_q);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h104, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h108 + 32'(4 * i), 1'b0, 1'b0);
      tick();
      checks++;
      if (dut.count_q !== 3'd2 || bus.id_pc !== 32'h104 + 32'(4 * i) ||
          bus.id_inst !== inst_of(32'h104 + 32'(4 * i))) begin
        failures++;
        $display("FAIL b2b[%0d] got count=%0d pc=%h exp count=2 pc=%h",
                 i, dut.count_q, bus.id_pc, 32'h104 + 32'(4 * i));
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.id_pc !== 32'h12C || dut.count_q !== 3'd1) begin
      failures++;
      $display("FAIL b2b_tail got pc=%h count=%0d exp pc=0000012c count=1", bus.id_pc, dut.count_q);
    end
    tick();
    checks++;
    if (bus.id_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty got v=%b exp v=0", bus.id_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h40 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (dut.count_q !== 3'd3 || bus.drop_err !== 1'b1 || bus.id_pc !== 32'h44) begin
      failures++;
      $display("FAIL pre_reset got count=%0d err=%b pc=%h exp count=3 err=1 pc=00000044",
               dut.count_q, bus.drop_err, bus.id_pc);
    end
    drive(1'b1, 32'h60, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 ||
        bus.fetch_hold !== 1'b0 || bus.q_full !== 1'b0 || bus.drop_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got v=%b pc=%h inst=%h hold=%b full=%b err=%b exp all 0",
               bus.id_valid, bus.id_pc, bus.id_inst, bus.fetch_hold, bus.q_full, bus.drop_err);
    end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 32'h250, 1'b0, 1'b0);
    tick();
    checks++;
    if (dut.count_q !== 3'd3 || bus.drop_err !== 1'b1 || bus.q_full !== 1'b0 || bus.id_pc !== 32'h204) begin
      failures++;
      $display("FAIL full_pop_push got count=%0d err=%b full=%b pc=%h exp count=3 err=1 full=0 pc=00000204",
               dut.count_q, bus.drop_err, bus.q_full, bus.id_pc);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 2; i < 4; i++) begin
      tick();
      checks++;
      if (bus.id_pc !== 32'h200 + 32'(4 * i)) begin
        failures++;
        $display("FAIL fpp_drain[%0d] got pc=%h exp pc=%h", i, bus.id_pc, 32'h200 + 32'(4 * i));
      end
    end
    tick();
    checks++;
    if (bus.id_valid !== 1'b0) begin
      failures++;
      $display("FAIL fpp_empty got v=%b exp v=0 (rejected word must be absent)", bus.id_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_in_order();
    test_fill_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_full_pop_push();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
